// File: rtl/ofs_fim_pcie_ss_rx_cpl_req_arb_pkg.sv
// Shared types and constants for the RX CplD/Req packet arbiter.
// Arbiter FSM states, source encodings and statistics counter width.
package ofs_fim_rx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPLD_PKT = 2'd1,
        REQ_PKT  = 2'd2
    } t_arb_state;

    localparam logic SRC_CPLD = 1'b0;
    localparam logic SRC_REQ  = 1'b1;
    localparam int   STAT_W   = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ofs_fim_pcie_ss_rx_cpl_req_arb_if.sv
// AXI-S beat bundle used for the CplD, Req and merged output streams.
// Master drives payload/valid, slave drives tready.
interface ofs_fim_pcie_ss_rx_cpl_req_arb_if #(
    parameter int DATA_WIDTH = 512,
    parameter int USER_W     = 1
);
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [USER_W-1:0]       tuser;

    modport master (output tvalid, tlast, tdata, tkeep, tuser, input tready);
    modport slave  (input tvalid, tlast, tdata, tkeep, tuser, output tready);
endinterface

// File: rtl/ofs_fim_pcie_ss_rx_cpl_req_arb_sched.sv
// Weighted priority scheduler choosing CplD vs Req at packet boundaries.
// Latency: sel_src is combinational; priority and weight count update on pkt_done.
// Backpressure: none; only observes valids and packet-completion strobes.
module ofs_fim_rx_arb_sched
    import ofs_fim_rx_arb_pkg::*;
#(
    parameter int CPLD_WEIGHT = 4,
    parameter int REQ_WEIGHT  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic cpld_valid,
    input  logic req_valid,
    input  logic pkt_done,
    input  logic pkt_src,
    output logic prio,
    output logic sel_src
);
    localparam int CNT_W = $clog2(max_int(CPLD_WEIGHT, REQ_WEIGHT) + 1);

    generate
        if (CPLD_WEIGHT < 1) begin : g_bad_cpld_weight
            $error("CPLD_WEIGHT must be at least 1");
        end
        if (REQ_WEIGHT < 1) begin : g_bad_req_weight
            $error("REQ_WEIGHT must be at least 1");
        end
    endgenerate

    logic             prio_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] prio_weight;
    logic             other_valid;

    assign other_valid = (prio_q == SRC_CPLD) ? req_valid : cpld_valid;
    assign prio_weight = (prio_q == SRC_CPLD) ? CNT_W'(CPLD_WEIGHT) : CNT_W'(REQ_WEIGHT);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign prio        = prio_q;

    always_comb begin
        sel_src = prio_q;
        if (cpld_valid && !req_valid) begin
            sel_src = SRC_CPLD;
        end else if (req_valid && !cpld_valid) begin
            sel_src = SRC_REQ;
        end
    end

    // A streak only counts while contested; an uncontested or off-priority packet breaks it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= SRC_CPLD;
            cnt_q  <= '0;
        end else if (pkt_done) begin
            if ((pkt_src != prio_q) || !other_valid) begin
                cnt_q <= '0;
            end else if (cnt_inc >= prio_weight) begin
                prio_q <= ~prio_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/ofs_fim_pcie_ss_rx_cpl_req_arb.sv
// Packet-level weighted merge of RX CplD and Req AXI-S streams; stats need OFS_FIM_RX_ARB_STATS_EN.
// Latency: 1 cycle input accept to out_tvalid; one IDLE bubble between packets.
// Backpressure: granted input tready = !out_tvalid || out_tready; non-granted tready held 0.
module ofs_fim_pcie_ss_rx_cpl_req_arb
    import ofs_fim_rx_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int USER_W      = 1,
    parameter int CPLD_WEIGHT = 4,
    parameter int REQ_WEIGHT  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    ofs_fim_pcie_ss_rx_cpl_req_arb_if.slave    cpld,
    ofs_fim_pcie_ss_rx_cpl_req_arb_if.slave    req,
    ofs_fim_pcie_ss_rx_cpl_req_arb_if.master   out,
    output logic                               out_src,
    output logic [STAT_W-1:0]                  stat_cpld_pkts,
    output logic [STAT_W-1:0]                  stat_req_pkts
);
    t_arb_state              state_q, state_d;
    logic                    can_load, load, pkt_done;
    logic                    grant_src, grant_vld, grant_last;
    logic [DATA_WIDTH-1:0]   grant_data;
    logic [DATA_WIDTH/8-1:0] grant_keep;
    logic [USER_W-1:0]       grant_user;
    logic                    prio, sel_src;

    logic                    out_vld_q, out_last_q, out_src_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [DATA_WIDTH/8-1:0] out_keep_q;
    logic [USER_W-1:0]       out_user_q;

    assign can_load    = !out_vld_q || out.tready;
    assign cpld.tready = (state_q == CPLD_PKT) && can_load;
    assign req.tready  = (state_q == REQ_PKT)  && can_load;

    assign grant_src  = (state_q == REQ_PKT);
    assign grant_vld  = ((state_q == CPLD_PKT) && cpld.tvalid) || ((state_q == REQ_PKT) && req.tvalid);
    assign grant_last = grant_src ? req.tlast : cpld.tlast;
    assign grant_data = grant_src ? req.tdata : cpld.tdata;
    assign grant_keep = grant_src ? req.tkeep : cpld.tkeep;
    assign grant_user = grant_src ? req.tuser : cpld.tuser;
    assign load       = grant_vld && can_load;
    assign pkt_done   = load && grant_last;

    ofs_fim_rx_arb_sched #(
        .CPLD_WEIGHT (CPLD_WEIGHT),
        .REQ_WEIGHT  (REQ_WEIGHT)
    ) u_sched (
        .clk        (clk),
        .rst        (rst),
        .cpld_valid (cpld.tvalid),
        .req_valid  (req.tvalid),
        .pkt_done   (pkt_done),
        .pkt_src    (grant_src),
        .prio       (prio),
        .sel_src    (sel_src)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The IDLE cycle only registers the grant, so tready never depends on tvalid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpld.tvalid && req.tvalid) begin
                    state_d = (prio == SRC_REQ) ? REQ_PKT : CPLD_PKT;
                end else if (cpld.tvalid || req.tvalid) begin
                    state_d = (sel_src == SRC_REQ) ? REQ_PKT : CPLD_PKT;
                end
            end
            CPLD_PKT, REQ_PKT: begin
                if (pkt_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_src_q  <= SRC_CPLD;
        end else if (load) begin
            out_vld_q  <= 1'b1;
            out_last_q <= grant_last;
            out_src_q  <= grant_src;
        end else if (out.tready) begin
            out_vld_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            out_data_q <= grant_data;
            out_keep_q <= grant_keep;
            out_user_q <= grant_user;
        end
    end

    assign out.tvalid = out_vld_q;
    assign out.tlast  = out_last_q;
    assign out.tdata  = out_data_q;
    assign out.tkeep  = out_keep_q;
    assign out.tuser  = out_user_q;
    assign out_src    = out_src_q;

`ifdef OFS_FIM_RX_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cpld_q, stat_req_q;
    logic              out_eop;

    assign out_eop = out_vld_q && out.tready && out_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cpld_q <= '0;
            stat_req_q  <= '0;
        end else if (out_eop) begin
            if (out_src_q == SRC_REQ) begin
                if (stat_req_q != '1) stat_req_q <= stat_req_q + STAT_W'(1);
            end else begin
                if (stat_cpld_q != '1) stat_cpld_q <= stat_cpld_q + STAT_W'(1);
            end
        end
    end

    assign stat_cpld_pkts = stat_cpld_q;
    assign stat_req_pkts  = stat_req_q;
`else
    assign stat_cpld_pkts = '0;
    assign stat_req_pkts  = '0;
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_rx_cpl_req_arb.sv
// Scoreboard bench for the RX CplD/Req arbiter: drivers push accepted beats, a monitor pops on output handshakes.
module tb_ofs_fim_pcie_ss_rx_cpl_req_arb;
    import ofs_fim_rx_arb_pkg::*;

    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int UW = 2;
`ifdef OFS_FIM_RX_ARB_STATS_EN
    localparam int EXP_STAT_C = 7;
    localparam int EXP_STAT_R = 3;
`else
    localparam int EXP_STAT_C = 0;
    localparam int EXP_STAT_R = 0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_src;
    logic [31:0] stat_c, stat_r;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_c[$];
    beat_t exp_r[$];
    logic  pat_q[$];
    int    acc_r = 0;
    bit    rand_stall = 1'b0;
    bit    watch_req = 1'b0, req_rdy_seen = 1'b0;
    bit    watch_cpld = 1'b0, cpld_early = 1'b0;

    always #5 clk = ~clk;

    ofs_fim_pcie_ss_rx_cpl_req_arb_if #(.DATA_WIDTH(DW), .USER_W(UW)) cpld_if ();
    ofs_fim_pcie_ss_rx_cpl_req_arb_if #(.DATA_WIDTH(DW), .USER_W(UW)) req_if ();
    ofs_fim_pcie_ss_rx_cpl_req_arb_if #(.DATA_WIDTH(DW), .USER_W(UW)) out_if ();

    ofs_fim_pcie_ss_rx_cpl_req_arb #(
        .DATA_WIDTH  (DW),
        .USER_W      (UW),
        .CPLD_WEIGHT (4),
        .REQ_WEIGHT  (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpld           (cpld_if),
        .req            (req_if),
        .out            (out_if),
        .out_src        (out_src),
        .stat_cpld_pkts (stat_c),
        .stat_req_pkts  (stat_r)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic src, input logic vld, input beat_t b);
        if (src) begin
            req_if.tvalid = vld; req_if.tdata = b.data; req_if.tkeep = b.keep;
            req_if.tuser  = b.user; req_if.tlast = b.last;
        end else begin
            cpld_if.tvalid = vld; cpld_if.tdata = b.data; cpld_if.tkeep = b.keep;
            cpld_if.tuser  = b.user; cpld_if.tlast = b.last;
        end
    endtask

    // Sends beats [0, stop_at) of an nbeats packet; stop_at < 0 sends it whole.
    task automatic send_pkt(input logic src, input int nbeats, input int id, input int stop_at);
        beat_t b;
        logic  hs;
        int    guard;
        b = '0;
        for (int i = 0; i < nbeats; i++) begin
            if (i == stop_at) break;
            b.data = {8'(src), 16'(id), 8'(i), $urandom};
            b.keep = (i == nbeats - 1) ? 8'h0F : 8'hFF;
            b.user = UW'($urandom);
            b.last = (i == nbeats - 1);
            drive(src, 1'b1, b);
            hs    = 1'b0;
            guard = 0;
            while (!hs) begin
                @(negedge clk);
                hs = src ? req_if.tready : cpld_if.tready;
                if (hs) begin
                    if (src) begin exp_r.push_back(b); acc_r++; end
                    else exp_c.push_back(b);
                end
                @(posedge clk);
                #1;
                guard++;
                if (!hs && guard > 1000) begin
                    checks++; errors++;
                    $display("FAIL handshake_timeout: src %0d pkt %0d beat %0d not accepted, expected within 1000 cycles", src, id, i);
                    drive(src, 1'b0, b);
                    return;
                end
            end
        end
        drive(src, 1'b0, b);
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while ((exp_c.size() + exp_r.size() + pat_q.size()) != 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk(name, 64'(exp_c.size() + exp_r.size() + pat_q.size()), 64'd0);
    endtask

    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.tready = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (watch_req && req_if.tready) req_rdy_seen = 1'b1;
        if (watch_cpld && cpld_if.tready) cpld_early = 1'b1;
    end

    // Monitor: per-source order, bit-exact payload, no interleave, stall stability, packet source pattern.
    bit    prev_stall = 1'b0;
    beat_t prev_beat, cur, e;
    logic  prev_src, pkt_src_m;
    bit    in_pkt = 1'b0;
    logic  p;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            in_pkt     = 1'b0;
        end else begin
            cur = {out_if.tdata, out_if.tkeep, out_if.tuser, out_if.tlast};
            if (prev_stall) begin
                checks++;
                if (!out_if.tvalid || cur !== prev_beat || out_src !== prev_src) begin
                    errors++;
                    $display("FAIL stall_hold: got vld %0b src %0b beat %h, expected vld 1 src %0b beat %h",
                             out_if.tvalid, out_src, cur, prev_src, prev_beat);
                end
            end
            if (out_if.tvalid && out_if.tready) begin
                checks++;
                if (in_pkt && out_src !== pkt_src_m) begin
                    errors++;
                    $display("FAIL interleave: got src %0b mid-packet, expected src %0b", out_src, pkt_src_m);
                end else if ((out_src ? exp_r.size() : exp_c.size()) == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got src %0b beat %h, expected no beat from that source", out_src, cur);
                end else begin
                    e = out_src ? exp_r.pop_front() : exp_c.pop_front();
                    if (e !== cur) begin
                        errors++;
                        $display("FAIL beat_src%0b: got %h, expected %h", out_src, cur, e);
                    end
                end
                if (out_if.tlast && pat_q.size() != 0) begin
                    p = pat_q.pop_front();
                    checks++;
                    if (p !== out_src) begin
                        errors++;
                        $display("FAIL pkt_order: got src %0b, expected src %0b", out_src, p);
                    end
                end
                in_pkt    = !out_if.tlast;
                pkt_src_m = out_src;
            end
            prev_stall = out_if.tvalid && !out_if.tready;
            prev_beat  = cur;
            prev_src   = out_src;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running at 1ms, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        rst = 1'b1;
        drive(SRC_CPLD, 1'b0, '0);
        drive(SRC_REQ, 1'b0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_tvalid", 64'(out_if.tvalid), 64'd0);
        chk("rst_out_tlast", 64'(out_if.tlast), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        chk("rst_cpld_tready", 64'(cpld_if.tready), 64'd0);
        chk("rst_req_tready", 64'(req_if.tready), 64'd0);
        chk("rst_stats", {stat_c, stat_r}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // CplD only: 100 packets of 1-4 beats; Req must never see tready.
        watch_req = 1'b1;
        for (int i = 0; i < 100; i++) send_pkt(SRC_CPLD, 1 + (i % 4), i, -1);
        drain("t1_drain");
        watch_req = 1'b0;
        chk("t1_req_tready_seen", 64'(req_rdy_seen), 64'd0);

        // Both saturated, single-beat: C,C,C,C,R x12, then C,C, then the remaining 38 R.
        for (int i = 0; i < 60; i++) pat_q.push_back((i % 5 == 4) ? SRC_REQ : SRC_CPLD);
        pat_q.push_back(SRC_CPLD);
        pat_q.push_back(SRC_CPLD);
        for (int i = 0; i < 38; i++) pat_q.push_back(SRC_REQ);
        fork
            for (int i = 0; i < 50; i++) send_pkt(SRC_CPLD, 1, 100 + i, -1);
            for (int i = 0; i < 50; i++) send_pkt(SRC_REQ, 1, 200 + i, -1);
        join
        drain("t2_drain");

        // Req packet mid-flight (beat 2 of 4) when CplD arrives: CplD waits for Req tlast.
        acc_r = 0;
        pat_q.push_back(SRC_REQ);
        pat_q.push_back(SRC_CPLD);
        fork
            begin
                send_pkt(SRC_REQ, 4, 300, -1);
                watch_cpld = 1'b0;
            end
            begin
                g = 0;
                while (acc_r < 2 && g < 1000) begin @(posedge clk); #1; g++; end
                watch_cpld = 1'b1;
                send_pkt(SRC_CPLD, 2, 400, -1);
            end
        join
        drain("t4_drain");
        chk("t4_cpld_tready_early", 64'(cpld_early), 64'd0);

        // Four contested CplD packets exhaust weight 4, handing priority to Req.
        for (int i = 0; i < 4; i++) pat_q.push_back(SRC_CPLD);
        pat_q.push_back(SRC_REQ);
        fork
            for (int i = 0; i < 4; i++) send_pkt(SRC_CPLD, 1, 450 + i, -1);
            send_pkt(SRC_REQ, 1, 460, -1);
        join
        drain("t5_prep_drain");
        chk("t5_prep_prio", 64'(dut.u_sched.prio_q), 64'(SRC_REQ));

        // Reset two beats into a 4-beat CplD packet; the registered beat is discarded.
        send_pkt(SRC_CPLD, 4, 500, 2);
        #1 rst = 1'b1;
        #1;
        chk("t5_out_tvalid", 64'(out_if.tvalid), 64'd0);
        chk("t5_cpld_tready", 64'(cpld_if.tready), 64'd0);
        chk("t5_req_tready", 64'(req_if.tready), 64'd0);
        chk("t5_state", 64'(dut.state_q), 64'(IDLE));
        chk("t5_prio", 64'(dut.u_sched.prio_q), 64'(SRC_CPLD));
        exp_c.delete();
        exp_r.delete();
        pat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("t5_stats_cleared", {stat_c, stat_r}, 64'd0);
        rst = 1'b0;

        // Post-reset traffic: 7 CplD + 3 Req packets, then the packet counters.
        fork
            for (int i = 0; i < 7; i++) send_pkt(SRC_CPLD, 1 + (i % 3), 600 + i, -1);
            for (int i = 0; i < 3; i++) send_pkt(SRC_REQ, 2, 700 + i, -1);
        join
        drain("t6_drain");
        chk("t6_stat_cpld", 64'(stat_c), 64'(EXP_STAT_C));
        chk("t6_stat_req", 64'(stat_r), 64'(EXP_STAT_R));

        // Both saturated with 3-beat packets under random output stalls.
        rand_stall = 1'b1;
        fork
            for (int i = 0; i < 8; i++) send_pkt(SRC_CPLD, 3, 800 + i, -1);
            for (int i = 0; i < 8; i++) send_pkt(SRC_REQ, 3, 900 + i, -1);
        join
        rand_stall = 1'b0;
        drain("t3_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
